// File: rtl/banked_dmem_pkg.sv
// Shared types and helpers for the banked data memory: access sizes, byte-enable
// generation, store lane replication and load extension.
package banked_dmem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE  = 2'd0,
        MEM_HALF  = 2'd1,
        MEM_WORD  = 2'd2,
        MEM_DWORD = 2'd3
    } mem_size_t;

    localparam int DWORD_BYTES = 8;

    function automatic logic [DWORD_BYTES-1:0] byte_enable(input mem_size_t size,
                                                           input logic [2:0] off);
        logic [DWORD_BYTES-1:0] base;
        case (size)
            MEM_BYTE: base = 8'h01;
            MEM_HALF: base = 8'h03;
            MEM_WORD: base = 8'h0F;
            default:  base = 8'hFF;
        endcase
        return base << off;
    endfunction

    function automatic logic misaligned(input mem_size_t size, input logic [2:0] off);
        case (size)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return off[0];
            MEM_WORD: return |off[1:0];
            default:  return |off;
        endcase
    endfunction

    // The store value is replicated so every possible byte offset sees its field.
    function automatic logic [63:0] lane_data(input mem_size_t size, input logic [63:0] wdata);
        case (size)
            MEM_BYTE: return {8{wdata[7:0]}};
            MEM_HALF: return {4{wdata[15:0]}};
            MEM_WORD: return {2{wdata[31:0]}};
            default:  return wdata;
        endcase
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] data, input mem_size_t size,
                                                input logic sgn);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        logic signed [63:0] r;
        b = data[7:0];
        h = data[15:0];
        w = data[31:0];
        case (size)
            MEM_BYTE: r = sgn ? 64'(b) : 64'(data[7:0]);
            MEM_HALF: r = sgn ? 64'(h) : 64'(data[15:0]);
            MEM_WORD: r = sgn ? 64'(w) : 64'(data[31:0]);
            default:  r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/banked_dmem_bank.sv
// Single-port 64-bit RAM bank with per-byte write enables, read-first registered
// output and a clock enable that freezes both the array and the output register.
module banked_dmem_bank
    import banked_dmem_pkg::*;
#(
    parameter int WORD_BITS = 15
) (
    input  logic                   clk,
    input  logic                   ce,
    input  logic [WORD_BITS-1:0]   addr,
    input  logic [DWORD_BYTES-1:0] be,
    input  logic [63:0]            wdata,
    output logic [63:0]            rdata
);

    logic [63:0] mem [0:(1<<WORD_BITS)-1];

    always_ff @(posedge clk) begin
        if (ce) begin
            rdata <= mem[addr];
            for (int i = 0; i < DWORD_BYTES; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/banked_dmem.sv
// N-bank byte-addressed data memory stage between EX and WB: size-typed loads and
// stores, sign extension, error flagging, sideband tag, two-cycle latency.
module banked_dmem
    import banked_dmem_pkg::*;
#(
    parameter int NUM_BANKS = 8,
    parameter int WORD_BITS = 15,
    parameter int ADDR_W    = 32,
    parameter int TAG_W     = 106
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              interlock,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic [TAG_W-1:0]  resp_tag
);

    localparam int BANK_BITS  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int BANK_IDX_W = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int BANK_LSB   = 3 + WORD_BITS;
    localparam int HI_LSB     = BANK_LSB + BANK_BITS;

    // Stage p0: decode and error check of the incoming request, RAM access issue.
    mem_size_t                size_p0;
    logic [2:0]               off_p0;
    logic [WORD_BITS-1:0]     word_p0;
    logic [BANK_IDX_W-1:0]    bank_p0;
    logic                     err_p0;
    logic                     acc_p0;
    logic                     wr_p0;
    logic [DWORD_BYTES-1:0]   be_p0;
    logic [63:0]              lane_p0;

    assign size_p0 = mem_size_t'(req_size);
    assign off_p0  = req_addr[2:0];
    assign word_p0 = req_addr[3 +: WORD_BITS];
    assign bank_p0 = BANK_IDX_W'((req_addr >> BANK_LSB) & ADDR_W'(NUM_BANKS - 1));
    assign err_p0  = (|(req_addr >> HI_LSB)) | misaligned(size_p0, off_p0);
    assign acc_p0  = req_valid & ~interlock & rstn;
    assign wr_p0   = acc_p0 & req_we & ~err_p0;
    assign be_p0   = byte_enable(size_p0, off_p0);
    assign lane_p0 = lane_data(size_p0, req_wdata);

    logic [63:0] bank_dout [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DWORD_BYTES-1:0] be_b;
        assign be_b = (wr_p0 && bank_p0 == BANK_IDX_W'(b)) ? be_p0 : '0;
        banked_dmem_bank #(.WORD_BITS(WORD_BITS)) u_bank (
            .clk   (clk),
            .ce    (~interlock),
            .addr  (word_p0),
            .be    (be_b),
            .wdata (lane_p0),
            .rdata (bank_dout[b])
        );
    end

    // Stage p1: request attributes travel alongside the RAM read.
    logic                  vld_p1;
    logic                  we_p1;
    logic                  err_p1;
    logic                  stall_q;
    logic [BANK_IDX_W-1:0] bank_p1;
    logic [2:0]            off_p1;
    mem_size_t             size_p1;
    logic                  sgn_p1;
    logic [TAG_W-1:0]      tag_p1;
    logic [63:0]           hold_p1;
    logic [63:0]           dout_sel_p1;
    logic [63:0]           ram_q_p1;
    logic [63:0]           field_p1;
    logic [63:0]           rdata_p1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p1  <= 1'b0;
            we_p1   <= 1'b0;
            err_p1  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            stall_q <= interlock;
            if (!interlock) begin
                vld_p1 <= acc_p0;
                we_p1  <= req_we;
                err_p1 <= err_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!interlock) begin
            bank_p1 <= bank_p0;
            off_p1  <= off_p0;
            size_p1 <= size_p0;
            sgn_p1  <= req_signed;
            tag_p1  <= req_tag;
        end
        if (interlock && !stall_q) hold_p1 <= dout_sel_p1;
    end

    // While stalled, the response is taken from the copy captured on stall entry.
    assign dout_sel_p1 = bank_dout[bank_p1];
    assign ram_q_p1    = stall_q ? hold_p1 : dout_sel_p1;
    assign field_p1    = ram_q_p1 >> {off_p1, 3'b000};
    assign rdata_p1    = (we_p1 | err_p1) ? 64'd0 : load_extend(field_p1, size_p1, sgn_p1);

    // Stage p2: registered response outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            resp_tag   <= '0;
        end else if (!interlock) begin
            resp_valid <= vld_p1;
            resp_rdata <= rdata_p1;
            resp_err   <= vld_p1 & err_p1;
            resp_tag   <= tag_p1;
        end
    end

endmodule

// File: tb/tb_banked_dmem.sv
// Directed scoreboard bench for banked_dmem: loads/stores, extension, bank and range
// boundaries, misalignment, interlock freeze and mid-operation reset.
module tb_banked_dmem;

    localparam int NUM_BANKS = 8;
    localparam int WORD_BITS = 15;
    localparam int ADDR_W    = 32;
    localparam int TAG_W     = 106;

    logic              clk;
    logic              rstn;
    logic              interlock;
    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic [TAG_W-1:0]  req_tag;
    logic              resp_valid;
    logic [63:0]       resp_rdata;
    logic              resp_err;
    logic [TAG_W-1:0]  resp_tag;

    banked_dmem #(
        .NUM_BANKS (NUM_BANKS),
        .WORD_BITS (WORD_BITS),
        .ADDR_W    (ADDR_W),
        .TAG_W     (TAG_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .interlock  (interlock),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .resp_tag   (resp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]      rdata;
        logic             err;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        nxt_exp;
    int          checks;
    int          failures;
    logic [31:0] tag_cnt;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp_v);
        end
    endtask

    function automatic logic [TAG_W-1:0] mk_tag();
        tag_cnt = tag_cnt + 32'd1;
        return {10'h2A5, tag_cnt, 32'($urandom()), 32'($urandom())};
    endfunction

    // One clock: retire the response visible this cycle, record the accepted request.
    task automatic tick();
        exp_t e;
        if (rstn && !interlock && resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 128'(resp_tag), 128'(0));
            end else begin
                e = sb.pop_front();
                chk("rdata", 128'(resp_rdata), 128'(e.rdata));
                chk("err", 128'(resp_err), 128'(e.err));
                chk("tag", 128'(resp_tag), 128'(e.tag));
            end
        end
        if (!rstn) sb.delete();
        if (rstn && !interlock && req_valid) sb.push_back(nxt_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [63:0] exp_rd, input logic exp_err);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_tag    = mk_tag();
        nxt_exp.rdata = exp_rd;
        nxt_exp.err   = exp_err;
        nxt_exp.tag   = req_tag;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic store(input logic [1:0] size, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic exp_err);
        issue(1'b1, size, 1'b0, addr, wdata, 64'd0, exp_err);
    endtask

    task automatic load(input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                        input logic [63:0] exp_rd, input logic exp_err);
        issue(1'b0, size, sgn, addr, 64'd0, exp_rd, exp_err);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        if (sb.size() > 0) chk("drain_timeout", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        logic [TAG_W-1:0] load_tag;
        logic             snap_valid;
        logic [63:0]      snap_rdata;
        logic             snap_err;
        logic [TAG_W-1:0] snap_tag;

        checks     = 0;
        failures   = 0;
        tag_cnt    = 32'd0;
        rstn       = 1'b0;
        interlock  = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_tag    = '0;

        repeat (3) tick();
        chk("rst_valid", 128'(resp_valid), 128'(0));
        chk("rst_rdata", 128'(resp_rdata), 128'(0));
        chk("rst_err", 128'(resp_err), 128'(0));
        chk("rst_tag", 128'(resp_tag), 128'(0));
        rstn = 1'b1;
        tick();

        // dword store/load and two-cycle latency
        store(2'd3, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 1'b0);
        load(2'd3, 1'b0, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 1'b0);
        load_tag = req_tag;
        tick();
        chk("lat_valid", 128'(resp_valid), 128'(1));
        chk("lat_tag", 128'(resp_tag), 128'(load_tag));
        chk("lat_rdata", 128'(resp_rdata), 128'(64'h0123_4567_89AB_CDEF));
        drain();

        // sub-dword fields and extension
        load(2'd0, 1'b0, 32'h0000_000F, 64'h0000_0000_0000_0001, 1'b0);
        load(2'd1, 1'b1, 32'h0000_000E, 64'h0000_0000_0000_0123, 1'b0);
        load(2'd2, 1'b1, 32'h0000_000C, 64'h0000_0000_0123_4567, 1'b0);
        load(2'd2, 1'b1, 32'h0000_0008, 64'hFFFF_FFFF_89AB_CDEF, 1'b0);
        load(2'd2, 1'b0, 32'h0000_0008, 64'h0000_0000_89AB_CDEF, 1'b0);
        store(2'd3, 32'h0000_0000, 64'd0, 1'b0);
        store(2'd0, 32'h0000_0005, 64'h0000_0000_0000_0080, 1'b0);
        load(2'd0, 1'b1, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        load(2'd0, 1'b0, 32'h0000_0005, 64'h0000_0000_0000_0080, 1'b0);
        load(2'd1, 1'b1, 32'h0000_0004, 64'hFFFF_FFFF_FFFF_8000, 1'b0);
        drain();

        // bank boundary, top word, range errors
        store(2'd2, 32'h0004_0000, 64'h0000_0000_DEAD_BEEF, 1'b0);
        store(2'd3, 32'h0003_FFF8, 64'h0000_0000_0000_0001, 1'b0);
        load(2'd2, 1'b0, 32'h0004_0000, 64'h0000_0000_DEAD_BEEF, 1'b0);
        load(2'd2, 1'b1, 32'h0004_0000, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0);
        load(2'd3, 1'b0, 32'h0003_FFF8, 64'h0000_0000_0000_0001, 1'b0);
        store(2'd3, 32'h0040_0000, 64'hBAD0_BAD0_BAD0_BAD0, 1'b1);
        load(2'd3, 1'b0, 32'h0040_0000, 64'd0, 1'b1);
        store(2'd3, 32'h001F_FFF8, 64'h55AA_55AA_1234_8765, 1'b0);
        load(2'd3, 1'b0, 32'h001F_FFF8, 64'h55AA_55AA_1234_8765, 1'b0);
        load(2'd0, 1'b1, 32'h001F_FFFF, 64'h0000_0000_0000_0055, 1'b0);
        store(2'd0, 32'h0020_0000, 64'hFF, 1'b1);
        load(2'd0, 1'b0, 32'h0020_0000, 64'd0, 1'b1);
        load(2'd3, 1'b0, 32'h0000_0000, 64'h0000_8000_0000_0000, 1'b0);
        drain();

        // misalignment
        load(2'd1, 1'b0, 32'h0000_0003, 64'd0, 1'b1);
        store(2'd2, 32'h0000_0002, 64'hFFFF_FFFF, 1'b1);
        load(2'd3, 1'b0, 32'h0000_0004, 64'd0, 1'b1);
        load(2'd3, 1'b0, 32'h0000_0000, 64'h0000_8000_0000_0000, 1'b0);
        drain();

        // interlock: three stall cycles after acceptance, store presented under stall
        load(2'd3, 1'b0, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 1'b0);
        load_tag   = req_tag;
        interlock  = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'd3;
        req_addr   = 32'h0000_0008;
        req_wdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        req_tag    = mk_tag();
        snap_valid = resp_valid;
        snap_rdata = resp_rdata;
        snap_err   = resp_err;
        snap_tag   = resp_tag;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 128'(resp_valid), 128'(snap_valid));
            chk("stall_rdata", 128'(resp_rdata), 128'(snap_rdata));
            chk("stall_err", 128'(resp_err), 128'(snap_err));
            chk("stall_tag", 128'(resp_tag), 128'(snap_tag));
        end
        interlock = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        tick();
        chk("stall_resp_valid", 128'(resp_valid), 128'(1));
        chk("stall_resp_tag", 128'(resp_tag), 128'(load_tag));
        chk("stall_resp_rdata", 128'(resp_rdata), 128'(64'h0123_4567_89AB_CDEF));
        drain();
        load(2'd3, 1'b0, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 1'b0);
        drain();

        // reset one cycle after a store
        store(2'd3, 32'h0000_0018, 64'h0BAD_F00D_1234_5678, 1'b0);
        rstn = 1'b0;
        tick();
        chk("midrst_valid", 128'(resp_valid), 128'(0));
        chk("midrst_rdata", 128'(resp_rdata), 128'(0));
        chk("midrst_tag", 128'(resp_tag), 128'(0));
        tick();
        chk("midrst_valid2", 128'(resp_valid), 128'(0));
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("postrst_valid", 128'(resp_valid), 128'(0));
        end
        load(2'd3, 1'b0, 32'h0000_0018, 64'h0BAD_F00D_1234_5678, 1'b0);
        load(2'd2, 1'b1, 32'h0000_001C, 64'h0000_0000_0BAD_F00D, 1'b0);
        drain();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/banked_dmem.md
Name: banked_dmem

Overview:
- Parametrised successor to the 2nd-generation data-memory pipeline stage: N-bank BRAM data memory with byte addressing, size-typed loads/stores, sign extension, error flagging and an opaque sideband tag carried alongside each access.
- Sits between EX and WB in the core pipeline.
- Honours the global interlock (stall) and has a fixed, documented latency.
- Single clock edge only; no negedge logic.

Parameters:
NUM_BANKS, 8, bank count; power of two, >=1.
WORD_BITS, 15, log2 of 64-bit words per bank.
ADDR_W, 32, byte address width.
TAG_W, 106, sideband width (pc + inst + u_rt + l_rt in the core); passed through untouched.

Ports:
clk  in  1  clock, all state on posedge.
rstn  in  1  synchronous active-low reset.
interlock  in  1  pipeline stall; freezes every register of this block.
req_valid  in  1  access request this cycle.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  mem_size_t: 0 byte, 1 half, 2 word, 3 dword.
req_signed  in  1  loads only: sign-extend result.
req_addr  in  ADDR_W  byte address.
req_wdata  in  64  store value, right-aligned.
req_tag  in  TAG_W  sideband.
resp_valid  out  1  response present in this cycle.
resp_rdata  out  64  load result, extended; 0 for stores and errors.
resp_err  out  1  misaligned or out-of-range access.
resp_tag  out  TAG_W  tag of the responding request.

Behaviour:
- Reset: synchronous, active-low on clk, as decided. While rstn=0: resp_valid=0, resp_rdata=0, resp_err=0, resp_tag=0, and no RAM write is issued. BRAM contents are not cleared.
- Acceptance: a request is accepted when req_valid=1, interlock=0 and rstn=1.
- Latency: a request accepted in cycle N has its response fields valid in cycle N+2, provided interlock stays low in N+1. Every interlock-high cycle extends that by one.
- Interlock:
  - All stage registers, including the RAM address and RAM output, hold.
  - Outputs stay stable.
  - No write enable is asserted.
  - On entry to a stall, RAM dout is captured into a hold register so the response survives the stall.
- Address split:
  - off = addr[2:0]
  - word = addr[3+WORD_BITS-1:3]
  - bank = next log2(NUM_BANKS) bits
  - all higher bits must be 0.
- Errors, checked in cycle N:
  - Range error: any higher bit is set.
  - Misaligned: off not a multiple of (1<<size).
  - On error: no write is issued, resp_err=1, resp_rdata=0, tag passes through.
- Stores:
  - Byte-enable = ((1<<(1<<size))-1) << off.
  - Data lane = req_wdata replicated into the byte positions.
  - Enables go only to the selected bank, which writes at the end of cycle N.
- Loads:
  - All banks are read. The selected bank's dout is muxed using the bank index and off pipelined to N+1.
  - The field at off is extracted, then zero- or sign-extended to 64 bits.
- RAM behaviour:
  - RAM is read-first: a load issued the cycle after a store to the same word returns the new data.
  - A store response has resp_rdata=0.
- Wrap-around: none. The top word of the top bank is valid; one byte above it is a range error.
- Reset mid-operation: in-flight requests are dropped. The first response after reset deassertion comes from a request accepted after reset.

Decomposition:
- Shared package (inst_package or a new mem_package):
  - mem_size_t enum
  - DWORD_BYTES=8
  - byte-enable and extend helper functions.
- Sub-module dmem_bank: single-port, byte-enable 64-bit RAM with one-cycle registered read and clock enable (driven by ~interlock). NUM_BANKS instances are generated.

Test Plan:
- Store dword 0x0123456789ABCDEF at 0x0000_0008, then load dword unsigned -> cycle N+2 resp_rdata=0x0123456789ABCDEF, resp_err=0, resp_tag echoes.
- Store byte 0x80 at 0x0000_0005; load byte signed -> 0xFFFFFFFFFFFFFF80; load byte unsigned -> 0x80; load half signed at 0x4 -> 0xFFFFFFFFFFFF8000.
- Store word 0xDEADBEEF at bank boundary 0x0004_0000 (bank 1, word 0), and store 0x1 at 0x0003_FFF8 (bank 0, top word) -> both read back intact; address 0x0040_0000 -> resp_err=1, no write, rdata 0.
- Load half at 0x3 -> resp_err=1, resp_rdata=0; a prior value at 0x0 is unchanged on re-read.
- Load accepted in N with interlock high in N+1..N+3 -> outputs frozen; response appears in N+5 with correct data; a store presented under interlock is not written.
- Issue store, then assert rstn=0 in N+1 -> resp_valid=0 through reset; the store, if committed in N, is visible afterwards; no stale response after rstn=1.
